// File: rtl/note_pkg.sv
// Shared note codes, half-period table, FSM states and target-period helper.
package note_pkg;

  localparam int unsigned NOTE_W    = 3;
  localparam int unsigned NUM_NOTES = 7;

  typedef enum logic [NOTE_W-1:0] {
    NOTE_NONE = 3'd0,
    NOTE_C4   = 3'd1,
    NOTE_D4   = 3'd2,
    NOTE_E4   = 3'd3,
    NOTE_F4   = 3'd4,
    NOTE_G4   = 3'd5,
    NOTE_A4   = 3'd6,
    NOTE_B4   = 3'd7
  } note_e;

  // Half-period of each note in microseconds, indexed by note code.
  localparam int unsigned K_US [1:NUM_NOTES] = '{1908, 1701, 1515, 1432, 1276, 1136, 1012};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_MEASURE,
    ST_LOCKED
  } state_e;

  // Full period in clocks of a generator tone: two half-periods of m*K+1.
  function automatic logic [31:0] note_period(input int unsigned k, input int unsigned m);
    return 32'(2 * (m * k + 1));
  endfunction

endpackage

// File: rtl/note_classifier.sv
// Registered window classifier: maps a measured period to a note code or NOTE_NONE.
module note_classifier
  import note_pkg::*;
#(
  parameter int unsigned M     = 20,
  parameter int unsigned CNT_W = 18,
  parameter int unsigned TOL   = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] period,
  output logic [2:0]       note_class
);

  localparam int unsigned PW = CNT_W + 1;
  localparam int unsigned DW = CNT_W + 2;

  logic signed [DW-1:0] diff [1:NUM_NOTES];
  logic        [DW-1:0] mag  [1:NUM_NOTES];
  logic        [2:0]    class_d;
  logic        [2:0]    class_q;

  // Seven parallel |period - P(K)| <= TOL window compares.
  always_comb begin
    class_d = 3'(NOTE_NONE);
    for (int i = 1; i <= int'(NUM_NOTES); i++) begin
      diff[i] = $signed(DW'(period)) - $signed(DW'(PW'(note_period(K_US[i], M))));
      mag[i]  = (diff[i] < 0) ? DW'(-diff[i]) : DW'(diff[i]);
      if (mag[i] <= DW'(TOL)) class_d = 3'(i);
    end
  end

  // Register the class so it lines up with the registered period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) class_q <= 3'(NOTE_NONE);
    else        class_q <= class_d;
  end

  assign note_class = class_q;

endmodule

// File: rtl/tone_detector.sv
// Measures the period of a square-wave tone and locks onto a C4..B4 note code.
module tone_detector
  import note_pkg::*;
#(
  parameter int unsigned m       = 20,
  parameter int unsigned CNT_W   = 18,
  parameter int unsigned TOL     = 1024,
  parameter int unsigned TIMEOUT = 200000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [2:0]       note_code,
  output logic             valid,
  output logic [CNT_W-1:0] period
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q,  prev_d;
  logic             edge_q,  edge_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             rise_c;
  logic             timeout_c;
  logic [2:0]       class_c;

  state_e           state_q, state_d;
  logic [2:0]       note_q,  note_d;
  logic             valid_q, valid_d;
  logic [2:0]       cand_q,  cand_d;

  assign rise_c = sync2_q & ~prev_q;

  // Synchronizer, edge pipeline and saturating period counter.
  always_comb begin
    sync1_d  = tone_in;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    edge_d   = rise_c;
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    period_d = period_q;
    if (rise_c) begin
      cnt_d    = '0;
      period_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    end
  end

  // Input path and measurement registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      edge_q   <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      edge_q   <= edge_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  // Classifier sees the period as it is loaded so its output pairs with edge_q.
  note_classifier #(
    .M     (m),
    .CNT_W (CNT_W),
    .TOL   (TOL)
  ) u_classifier (
    .clk        (clk),
    .rst_n      (rst_n),
    .period     (period_d),
    .note_class (class_c)
  );

  // A rise in this cycle resets cnt, so it pre-empts the timeout.
  assign timeout_c = (state_q != ST_IDLE) && (cnt_q == CNT_W'(TIMEOUT)) && !rise_c;

  // Lock FSM next-state and output logic; acts one cycle after each rise.
  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    valid_d = valid_q;
    cand_d  = cand_q;
    if (edge_q) begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ARMED;
        ST_ARMED: begin
          cand_d  = class_c;
          state_d = ST_MEASURE;
        end
        ST_MEASURE: begin
          if ((class_c != 3'(NOTE_NONE)) && (class_c == cand_q)) begin
            note_d  = cand_q;
            valid_d = 1'b1;
            state_d = ST_LOCKED;
          end else begin
            cand_d  = class_c;
          end
        end
        ST_LOCKED: begin
          if (class_c != note_q) begin
            note_d  = 3'(NOTE_NONE);
            valid_d = 1'b0;
            cand_d  = class_c;
            state_d = ST_MEASURE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_c) begin
      state_d = ST_IDLE;
      note_d  = 3'(NOTE_NONE);
      valid_d = 1'b0;
      cand_d  = 3'(NOTE_NONE);
    end
  end

  // Lock FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      note_q  <= 3'(NOTE_NONE);
      valid_q <= 1'b0;
      cand_q  <= 3'(NOTE_NONE);
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      valid_q <= valid_d;
      cand_q  <= cand_d;
    end
  end

  assign note_code = note_q;
  assign valid     = valid_q;
  assign period    = period_q;

endmodule

// File: tb/tb_tone_detector.sv
// Directed bench for tone_detector, scaled to m=1 so every tone fits a short run.
module tb_tone_detector;
  import note_pkg::*;

  localparam int unsigned M_T   = 1;
  localparam int unsigned CW    = 14;
  localparam int unsigned TOL_T = 50;
  localparam int unsigned TO_T  = 4500;

  // Full periods 2*(1*K+1) for m=1.
  localparam int P_C4 = 3818;
  localparam int P_F4 = 2866;
  localparam int P_G4 = 2554;
  localparam int P_A4 = 2274;
  localparam int P_B4 = 2026;
  localparam int P_GAP = 2400;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tone_in;
  logic [2:0]    note_code;
  logic          valid;
  logic [CW-1:0] period;

  int checks = 0;
  int passed = 0;

  tone_detector #(
    .m       (M_T),
    .CNT_W   (CW),
    .TOL     (TOL_T),
    .TIMEOUT (TO_T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tone_in   (tone_in),
    .note_code (note_code),
    .valid     (valid),
    .period    (period)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input int n);
    tone_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic tone_period(input int p);
    drive(1'b1, p / 2);
    drive(1'b0, p - p / 2);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    tone_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int jp;
    int prevp;
    rst_n   = 1'b0;
    tone_in = 1'b0;
    @(negedge clk);
    check("rst_note", 32'(note_code), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_period", 32'(period), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // F4: lock after the third rise, stays locked.
    tone_period(P_F4);
    tone_period(P_F4);
    drive(1'b1, 2);
    check("f4_prelock_valid", 32'(valid), 0);
    drive(1'b1, 4);
    check("f4_lock_valid", 32'(valid), 1);
    check("f4_lock_note", 32'(note_code), 4);
    check("f4_period", 32'(period), 32'(P_F4));
    drive(1'b1, P_F4 / 2 - 6);
    drive(1'b0, P_F4 - P_F4 / 2);
    tone_period(P_F4);
    drive(1'b1, 6);
    check("f4_hold_valid", 32'(valid), 1);
    check("f4_hold_note", 32'(note_code), 4);

    // C4 lock then switch to G4: unlock at the first G4 rise, relock one period later.
    do_reset();
    tone_period(P_C4);
    tone_period(P_C4);
    drive(1'b1, 6);
    check("c4_note", 32'(note_code), 1);
    check("c4_valid", 32'(valid), 1);
    drive(1'b1, P_C4 / 2 - 6);
    drive(1'b0, P_C4 - P_C4 / 2);
    tone_period(P_G4);
    drive(1'b1, 6);
    check("c4g4_unlock_note", 32'(note_code), 0);
    check("c4g4_unlock_valid", 32'(valid), 0);
    check("c4g4_period", 32'(period), 32'(P_G4));
    drive(1'b1, P_G4 / 2 - 6);
    drive(1'b0, P_G4 - P_G4 / 2);
    drive(1'b1, 6);
    check("g4_note", 32'(note_code), 5);
    check("g4_valid", 32'(valid), 1);

    // F4 with +-45 jitter stays inside the window and locks.
    do_reset();
    prevp = 0;
    for (int i = 0; i < 5; i++) begin
      jp = (i % 2 == 0) ? P_F4 + 45 : P_F4 - 45;
      drive(1'b1, 6);
      check("jit45_valid", 32'(valid), (i >= 2) ? 1 : 0);
      check("jit45_note", 32'(note_code), (i >= 2) ? 4 : 0);
      if (i > 0) check("jit45_period", 32'(period), 32'(prevp));
      drive(1'b1, jp / 2 - 6);
      drive(1'b0, jp - jp / 2);
      prevp = jp;
    end

    // F4 with +-55 jitter falls outside the window and never locks.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      jp = (i % 2 == 0) ? P_F4 + 55 : P_F4 - 55;
      drive(1'b1, 6);
      check("jit55_valid", 32'(valid), 0);
      check("jit55_note", 32'(note_code), 0);
      drive(1'b1, jp / 2 - 6);
      drive(1'b0, jp - jp / 2);
    end

    // Period between G4 and A4 never classifies.
    do_reset();
    tone_period(P_GAP);
    tone_period(P_GAP);
    tone_period(P_GAP);
    drive(1'b1, 6);
    check("gap_note", 32'(note_code), 0);
    check("gap_valid", 32'(valid), 0);
    check("gap_period", 32'(period), 32'(P_GAP));
    drive(1'b0, 10);

    // A4 lock, then tone held low until timeout.
    do_reset();
    tone_period(P_A4);
    tone_period(P_A4);
    drive(1'b1, 6);
    check("a4_note", 32'(note_code), 6);
    check("a4_valid", 32'(valid), 1);
    drive(1'b1, P_A4 / 2 - 6);
    drive(1'b0, P_A4 - P_A4 / 2);
    drive(1'b0, 4400 - P_A4);
    check("a4_before_to_valid", 32'(valid), 1);
    drive(1'b0, 200);
    check("a4_to_valid", 32'(valid), 0);
    check("a4_to_note", 32'(note_code), 0);
    check("a4_to_state", 32'(dut.state_q), 32'(ST_IDLE));

    // B4 lock, reset pulse mid-period, then three fresh rises to relock.
    do_reset();
    tone_period(P_B4);
    tone_period(P_B4);
    drive(1'b1, 6);
    check("b4_note", 32'(note_code), 7);
    check("b4_valid", 32'(valid), 1);
    drive(1'b1, P_B4 / 2 - 6);
    drive(1'b0, 500);
    rst_n = 1'b0;
    #1;
    check("b4_rst_note", 32'(note_code), 0);
    check("b4_rst_valid", 32'(valid), 0);
    check("b4_rst_period", 32'(period), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, P_B4 / 2 - 501);
    tone_period(P_B4);
    drive(1'b1, 6);
    check("b4_relock_early_valid", 32'(valid), 0);
    drive(1'b1, P_B4 / 2 - 6);
    drive(1'b0, P_B4 - P_B4 / 2);
    drive(1'b1, 6);
    check("b4_relock_valid", 32'(valid), 1);
    check("b4_relock_note", 32'(note_code), 7);
    check("b4_relock_period", 32'(period), 32'(P_B4));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tone_detector.md
# tone_detector

Measures the period of an incoming square-wave tone and identifies which note of the team's C4–B4 scale it is. This is the receiving end of the speaker note generators: it decodes the waveform they emit, with half-period equal to m·K+1 clocks, back into a note code. It sits between an external tone input pin and the display/score logic, in the same system clock domain as the generators.

## Interface
- `m`, default 20: system clock frequency in MHz. Must match the generators.
- `CNT_W`, default 18: width of the period counter and of `period`.
- `TOL`, default 1024: accepted ± deviation, in clocks, from a table period.
- `TIMEOUT`, default 200000: clocks without a rising edge before the tone is declared absent.
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `tone_in` input 1: asynchronous square wave. It is synchronized internally.
- `note_code` output 3: 0 = none; 1..7 = C4, D4, E4, F4, G4, A4, B4.
- `valid` output 1: high while a note is locked.
- `period` output CNT_W: last measured full period in clocks, rising edge to rising edge.

## Operation
- Input path:
  - Two-flop synchronizer, then a previous-sample flop.
  - `rise` = synchronized sample is 1 and previous sample is 0.
- Period counter `cnt`:
  - Increments every clock and saturates at 2^CNT_W−1.
  - On `rise`: `period` ← `cnt`+1 (saturating), and `cnt` ← 0.
- Note table, K in µs of half-period: C4 1908, D4 1701, E4 1515, F4 1432, G4 1276, A4 1136, B4 1012.
  - Target full period P(K) = 2·(m·K+1). For example, F4 at m=20 is 57282 clocks.
  - A measured period classifies as note i if |period − P(K_i)| ≤ TOL; otherwise it classifies as 0.
  - With default TOL, the note windows cannot overlap.
- FSM states:
  - IDLE: no reference edge yet. `cnt` runs, nothing is classified. First `rise` → ARMED.
  - ARMED: one edge seen. On `rise`, classify, store the result as `cand`, then → MEASURE.
  - MEASURE: on `rise`, classify.
    - Nonzero and equal to `cand` → LOCKED; set `note_code`=`cand`, `valid`=1.
    - Otherwise `cand` ← new class and stay in MEASURE.
  - LOCKED: on `rise`, classify.
    - Equal to `note_code` → stay.
    - Different or 0 → `note_code`=0, `valid`=0, `cand` ← new class, → MEASURE.
- Timeout: in any state other than IDLE, `cnt` reaching TIMEOUT forces the next state to IDLE, with `note_code`=0, `valid`=0, `cand`=0.
- Timeout and `rise` in the same cycle: `rise` wins.
- Widths: P(K) is computed at CNT_W+1 bits. The difference is computed signed, and its absolute value is compared against TOL.

## Timing
- Reset values: `note_code`=0, `valid`=0, `period`=0, `cnt`=0, state IDLE, synchronizer flops 0.
- Reset deassertion takes effect on the next `clk` edge. Reset asserted mid-lock clears all outputs immediately.
- `rise` is asserted 3 clocks after a `tone_in` transition that meets setup.
- `period` is updated 1 clock after the `rise` cycle.
- `note_code` and `valid` are updated 2 clocks after the `rise` cycle, through a registered classifier.
- Lock needs 3 rising edges, i.e. 2 consecutive matching periods. Unlock needs 1 mismatching period or a timeout.
- `valid`=1 guarantees `note_code`≠0. `note_code` never changes directly between two nonzero values.

## Structure
- Package `note_pkg`:
  - Note codes NOTE_NONE and NOTE_C4..NOTE_B4.
  - Half-period constant array K[1:7].
  - FSM state enum.
  - Function computing P(K, m).
- Sub-module `note_classifier`:
  - Inputs: period. Output: registered 3-bit class.
  - Contains the 7 parallel window compares.
  - Instanced once.

## Test plan
- Square wave, period 57282 (F4), 5 periods → `valid` rises 2 clocks after the 3rd rise; `note_code`=4; `period`=57282.
- Lock on C4 (76322), then switch to G4 (51042) → at the first G4 rise `note_code`=0 and `valid`=0; one period later `note_code`=5 and `valid`=1.
- F4 with alternating ±900-clock jitter → stays locked. Jitter of ±1100 → never locks.
- Period 50000 (between G4 and A4) → `note_code` stays 0, `valid` stays 0, `period`=50000.
- Locked on A4, then `tone_in` held low → `valid`=0 when `cnt` hits 200000; state IDLE.
- Locked on B4, `rst_n` pulsed low for 1 clock mid-period → outputs 0 immediately. A full 3 rising edges are needed before relock.
